mem_port_arbiter: RTL and testbench

Arbitrates the single shared memory port of the pipelined processor between the fetch stage (instruction reads) and the memory stage (data reads/writes). It serialises requests through an issue/wait FSM with a response timeout and an address-bounds check. Out-of-bound addresses and timeouts are reported as per-port error pulses, which the pipeline converts to the memory-error status 4'b0010. Data requests have priority, with a starvation cap that protects fetch.

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single memory port between the fetch stage (instruction reads)
//   and the memory stage (data reads/writes). One access at a time moves
//   through IDLE -> ISSUE -> WAIT -> DONE. Out-of-range addresses and
//   response timeouts come back as an error flag with the ready pulse.
//   Data requests have priority. A starvation counter lets fetch through
//   after STARVE_MAX back-to-back data grants that fetch sat through.
//
// Handshake: a requester raises req and holds req/addr (plus we/wdata on
//   the data port) stable until it sees its one-cycle ready pulse. err and
//   rdata are valid only with that pulse. In the cycle after ready the
//   requester drops req or presents its next request. On the memory side,
//   mem_en is a one-cycle strobe with mem_we/mem_addr/mem_wdata. mem_ack is
//   a one-cycle completion pulse with mem_rdata, and it is only looked at
//   in WAIT.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   if_req/if_addr               fetch request (read only)
//   if_ready/if_err/if_rdata     fetch completion
//   dm_req/dm_we/dm_addr/dm_wdata data request
//   dm_ready/dm_err/dm_rdata     data completion
//   mem_en/mem_we/mem_addr/mem_wdata  memory access strobe and payload
//   mem_ack/mem_rdata            memory completion
//   busy                         high whenever the FSM is not IDLE
//   fsm_state                    current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE)
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_SIZE   = 8192,
  parameter int ACC_BYTES  = 8,
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_err,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic              dm_err,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  // Highest legal start address. The check is addr > MAX_ADDR, so that
  // addr + ACC_BYTES never has to be formed and cannot overflow.
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_SIZE - ACC_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            state, state_nx;
  logic              owner_if;   // 1: fetch owns the current access
  logic              lat_we;
  logic              err_flag;
  logic [TW-1:0]     timer;
  logic [SW-1:0]     starve_cnt;
  logic              any_req;
  logic              grant_if;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_oob;

  // Arbitration and next state.
  always_comb begin
    state_nx = state;
    any_req  = if_req | dm_req;
    grant_if = if_req & (~dm_req | (starve_cnt == SW'(STARVE_MAX)));
    sel_addr = grant_if ? if_addr : dm_addr;
    sel_oob  = (sel_addr > MAX_ADDR);
    case (state)
      S_IDLE:  if (any_req) state_nx = sel_oob ? S_DONE : S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (mem_ack || timer == TW'(TIMEOUT - 1)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner_if   <= 1'b0;
      lat_we     <= 1'b0;
      err_flag   <= 1'b0;
      timer      <= '0;
      starve_cnt <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            owner_if <= grant_if;
            lat_we   <= grant_if ? 1'b0 : dm_we;
            mem_addr <= sel_addr;
            err_flag <= sel_oob;
            if (!grant_if) mem_wdata <= dm_wdata;
            // Counts data grants that fetch had to watch go by.
            if (grant_if || !if_req)
              starve_cnt <= '0;
            else if (starve_cnt != SW'(STARVE_MAX))
              starve_cnt <= starve_cnt + SW'(1);
          end
        end
        S_ISSUE: timer <= '0;
        S_WAIT: begin
          timer <= timer + TW'(1);
          if (mem_ack) begin
            // When ack and timeout coincide, the ack wins.
            err_flag <= 1'b0;
            if (!lat_we) begin
              if (owner_if) if_rdata <= mem_rdata;
              else          dm_rdata <= mem_rdata;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            err_flag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // All outputs decode from registered state only.
  assign mem_en    = (state == S_ISSUE);
  assign mem_we    = (state == S_ISSUE) & lat_we;
  assign if_ready  = (state == S_DONE) & owner_if;
  assign dm_ready  = (state == S_DONE) & ~owner_if;
  assign if_err    = if_ready & err_flag;
  assign dm_err    = dm_ready & err_flag;
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Inputs change on the falling edge and outputs
// are sampled on the falling edge. Each request pushes its expected
// {port, err, rdata} onto exp_q, and a monitor pops and compares it on
// every ready pulse.
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int RW = 2 + DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, dm_req, dm_we, mem_ack;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic          if_ready, if_err, dm_ready, dm_err, mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [1:0]    fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [RW-1:0] exp_q[$];
  logic [DW-1:0] sh_if, sh_dm;

  typedef struct {
    logic          port_if;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            ack_dly;   // -1: memory never acks
    logic [DW-1:0] rdata;
    logic          exp_err;
    int            exp_lat;   // cycles from request to ready
  } vec_t;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_SIZE(8192), .ACC_BYTES(8),
    .TIMEOUT(16), .STARVE_MAX(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_err(if_err), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_err(dm_err), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .fsm_state(fsm_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (if_ready || dm_ready) begin
      if (if_ready && dm_ready) check("both_ready", 1'b1, 1'b0);
      if (exp_q.size() == 0) begin
        check("unexpected_ready", {if_ready, dm_ready}, 2'b00);
      end else begin
        check("resp", {if_ready, (if_ready ? if_err : dm_err),
                       (if_ready ? if_rdata : dm_rdata)}, exp_q.pop_front());
      end
    end
  end

  // Driver for one isolated transaction, also acting as the memory.
  task automatic run_vec(input vec_t v);
    int ie, lat;
    logic [DW-1:0] exp_rd;
    logic oob;
    oob    = (v.exp_lat == 1);
    exp_rd = v.port_if ? sh_if : sh_dm;
    if (!v.exp_err && !v.we) begin
      exp_rd = v.rdata;
      if (v.port_if) sh_if = v.rdata;
      else           sh_dm = v.rdata;
    end
    exp_q.push_back({v.port_if, v.exp_err, exp_rd});
    if (v.port_if) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end
    ie = -1; lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (mem_en) begin
        ie = k;
        check("issue_cycle", k, oob ? 0 : 1);
        check("mem_addr", mem_addr, v.addr);
        check("mem_we", mem_we, v.we);
        if (v.we) check("mem_wdata", mem_wdata, v.wdata);
      end
      if (ie > 0 && v.ack_dly >= 0 && k == ie + 1 + v.ack_dly) begin
        mem_ack = 1'b1; mem_rdata = v.rdata;
      end
      if (if_ready || dm_ready) begin
        lat = k;
        break;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    check("latency", lat, v.exp_lat);
  endtask

  initial begin
    vec_t vecs[10];
    vec_t v;
    logic exp_order[8];
    logic got_order[8];
    int g, ncomp;
    logic ack_pend;

    vecs[0] = '{1'b0, 1'b0, 64'h100, 64'h0, 0, 64'hDEADBEEF, 1'b0, 3};
    vecs[1] = '{1'b1, 1'b0, 64'd8184, 64'h0, 2, {$urandom, $urandom}, 1'b0, 5};
    vecs[2] = '{1'b1, 1'b0, 64'd8185, 64'h0, -1, 64'h0, 1'b1, 1};
    vecs[3] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, -1, 64'h0, 1'b1, 1};
    vecs[4] = '{1'b0, 1'b1, 64'h200, 64'h55, 1, {$urandom, $urandom}, 1'b0, 4};
    vecs[5] = '{1'b1, 1'b0, 64'h0, 64'h0, 4, {$urandom, $urandom}, 1'b0, 7};
    vecs[6] = '{1'b0, 1'b0, 64'h8, 64'h0, 0, {$urandom, $urandom}, 1'b0, 3};
    vecs[7] = '{1'b0, 1'b0, 64'd8184, 64'h0, 3, {$urandom, $urandom}, 1'b0, 6};
    vecs[8] = '{1'b0, 1'b1, 64'h1000, {$urandom, $urandom}, 0, 64'h0, 1'b0, 3};
    vecs[9] = '{1'b0, 1'b0, 64'h300, 64'h0, -1, 64'h0, 1'b1, 18};

    // Reset.
    rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    sh_if = '0; sh_dm = '0;
    repeat (3) @(negedge clk);
    check("rst_state", fsm_state, 2'd0);
    check("rst_ctrl", {mem_en, mem_we, if_ready, dm_ready, if_err, dm_err, busy}, 7'd0);
    check("rst_data", {mem_addr, mem_wdata, if_rdata, dm_rdata}, 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors; the last one times out.
    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
      @(negedge clk);
    end

    // Late ack after the timeout (T+20) must be ignored.
    mem_ack = 1'b1; mem_rdata = 64'hBAD;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_idle", {busy, fsm_state}, 3'd0);
    check("late_ack_rdata", dm_rdata, sh_dm);

    // Both requesters held: expected grant order D D D F D D D F.
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({exp_order[i], 1'b0, DW'(100 + i)});
      got_order[i] = 1'bx;
    end
    sh_if = 64'd107; sh_dm = 64'd106;
    if_req = 1'b1; if_addr = 64'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h80;
    g = 0; ncomp = 0; ack_pend = 1'b0;
    for (int k = 0; k < 100 && ncomp < 8; k++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_en) begin
        if (g < 8) got_order[g] = (mem_addr == 64'h40);
        g++;
        ack_pend = 1'b1;
      end else if (ack_pend) begin
        mem_ack = 1'b1; mem_rdata = DW'(100 + ncomp); ack_pend = 1'b0;
      end
      if (if_ready || dm_ready) ncomp++;
    end
    if_req = 1'b0; dm_req = 1'b0;
    check("starve_done", ncomp, 8);
    for (int i = 0; i < 8; i++) check($sformatf("grant_%0d", i), got_order[i], exp_order[i]);
    @(negedge clk);

    // Reset while in WAIT abandons the access.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h500;
    for (int k = 0; k < 5 && !mem_en; k++) @(negedge clk);
    check("rstw_issue", mem_en, 1'b1);
    @(negedge clk);
    check("rstw_in_wait", fsm_state, 2'd2);
    rst_n = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    check("rstw_state", fsm_state, 2'd0);
    check("rstw_ctrl", {mem_en, mem_we, if_ready, dm_ready, if_err, dm_err, busy}, 7'd0);
    check("rstw_data", {mem_addr, mem_wdata, if_rdata, dm_rdata}, 256'd0);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 64'hBAD;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rstw_idle", {busy, fsm_state}, 3'd0);
    sh_if = '0; sh_dm = '0;

    // Normal read after the mid-transaction reset.
    v = '{1'b0, 1'b0, 64'h10, 64'h0, 0, 64'h1234_5678, 1'b0, 3};
    run_vec(v);
    repeat (2) @(negedge clk);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
